// File: rtl/rom_fetch_unit.sv
// ROM fetch front end: serves byte reads from SRAM port 1 through a one-word line buffer.
// Optional next-word prefetch buffer is enabled by defining ROM_PREFETCH_EN.
module rom_fetch_unit #(
  parameter int ADDR_W  = 11,
  parameter int WORD_AW = 9
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n,
  input  logic               flush,
  input  logic               req_valid,
  input  logic [ADDR_W-1:0]  req_addr,
  output logic               req_ready,
  output logic               rsp_valid,
  output logic [7:0]         rsp_data,
  output logic               oram_csb,
  output logic [WORD_AW-1:0] oram_addr,
  input  logic [31:0]        oram_value
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_RESP
`ifdef ROM_PREFETCH_EN
    , S_PF_ISSUE, S_PF_WAIT
`endif
  } state_t;

  state_t state_q, state_d;
  logic               req_ready_q, req_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [7:0]         rsp_data_q, rsp_data_d;
  logic               oram_csb_q, oram_csb_d;
  logic [WORD_AW-1:0] oram_addr_q, oram_addr_d;
  logic               line_valid_q, line_valid_d;
  logic [WORD_AW-1:0] line_tag_q, line_tag_d;
  logic [31:0]        line_data_q, line_data_d;
  logic [WORD_AW-1:0] word_q, word_d;
  logic [1:0]         sel_q, sel_d;
  logic               kill_q, kill_d;
  logic [WORD_AW-1:0] req_word;
  logic               line_hit;
`ifdef ROM_PREFETCH_EN
  logic               pf_valid_q, pf_valid_d;
  logic [WORD_AW-1:0] pf_tag_q, pf_tag_d;
  logic [31:0]        pf_data_q, pf_data_d;
  logic               fill_q, fill_d;
  logic [WORD_AW-1:0] next_word;
  logic               pf_hit;
`endif

  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] s);
    case (s)
      2'd0:    pick_byte = w[7:0];
      2'd1:    pick_byte = w[15:8];
      2'd2:    pick_byte = w[23:16];
      default: pick_byte = w[31:24];
    endcase
  endfunction

  assign req_word = req_addr[ADDR_W-1:2];
  assign line_hit = line_valid_q && !flush && (line_tag_q == req_word);
`ifdef ROM_PREFETCH_EN
  assign next_word = word_q + 1'b1;
  assign pf_hit    = pf_valid_q && !flush && (pf_tag_q == req_word);
`endif

  always_comb begin
    state_d      = state_q;
    rsp_data_d   = rsp_data_q;
    oram_addr_d  = oram_addr_q;
    line_valid_d = line_valid_q & ~flush;
    line_tag_d   = line_tag_q;
    line_data_d  = line_data_q;
    word_d       = word_q;
    sel_d        = sel_q;
    kill_d       = kill_q;
`ifdef ROM_PREFETCH_EN
    pf_valid_d   = pf_valid_q & ~flush;
    pf_tag_d     = pf_tag_q;
    pf_data_d    = pf_data_q;
    fill_d       = fill_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (line_hit) begin
            rsp_data_d = pick_byte(line_data_q, req_addr[1:0]);
            state_d    = S_RESP;
`ifdef ROM_PREFETCH_EN
            fill_d     = 1'b0;
          end else if (pf_hit) begin
            line_data_d  = pf_data_q;
            line_tag_d   = pf_tag_q;
            line_valid_d = 1'b1;
            pf_valid_d   = 1'b0;
            rsp_data_d   = pick_byte(pf_data_q, req_addr[1:0]);
            fill_d       = 1'b0;
            state_d      = S_RESP;
`endif
          end else begin
            word_d      = req_word;
            sel_d       = req_addr[1:0];
            oram_addr_d = req_word;
            kill_d      = 1'b0;
            state_d     = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        kill_d  = kill_q | flush;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A flush seen anywhere in the fill still returns data but leaves the line invalid.
        line_data_d  = oram_value;
        line_tag_d   = word_q;
        line_valid_d = ~(kill_q | flush);
        rsp_data_d   = pick_byte(oram_value, sel_q);
        state_d      = S_RESP;
`ifdef ROM_PREFETCH_EN
        fill_d       = 1'b1;
`endif
      end
      S_RESP: begin
        state_d = S_IDLE;
`ifdef ROM_PREFETCH_EN
        if (fill_q && !(pf_valid_q && pf_tag_q == next_word)
                   && !(line_valid_q && line_tag_q == next_word)) begin
          word_d      = next_word;
          oram_addr_d = next_word;
          kill_d      = 1'b0;
          fill_d      = 1'b0;
          state_d     = S_PF_ISSUE;
        end
      end
      S_PF_ISSUE: begin
        kill_d  = kill_q | flush;
        state_d = S_PF_WAIT;
      end
      S_PF_WAIT: begin
        pf_data_d  = oram_value;
        pf_tag_d   = word_q;
        pf_valid_d = ~(kill_q | flush);
        state_d    = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
`ifdef ROM_PREFETCH_EN
    oram_csb_d  = !((state_d == S_ISSUE) || (state_d == S_PF_ISSUE));
`else
    oram_csb_d  = !(state_d == S_ISSUE);
`endif
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      oram_csb_q   <= 1'b1;
      oram_addr_q  <= '0;
      line_valid_q <= 1'b0;
      line_tag_q   <= '0;
      line_data_q  <= '0;
      word_q       <= '0;
      sel_q        <= '0;
      kill_q       <= 1'b0;
`ifdef ROM_PREFETCH_EN
      pf_valid_q   <= 1'b0;
      pf_tag_q     <= '0;
      pf_data_q    <= '0;
      fill_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      oram_csb_q   <= oram_csb_d;
      oram_addr_q  <= oram_addr_d;
      line_valid_q <= line_valid_d;
      line_tag_q   <= line_tag_d;
      line_data_q  <= line_data_d;
      word_q       <= word_d;
      sel_q        <= sel_d;
      kill_q       <= kill_d;
`ifdef ROM_PREFETCH_EN
      pf_valid_q   <= pf_valid_d;
      pf_tag_q     <= pf_tag_d;
      pf_data_q    <= pf_data_d;
      fill_q       <= fill_d;
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign oram_csb  = oram_csb_q;
  assign oram_addr = oram_addr_q;

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Scoreboard bench for rom_fetch_unit: expected responses and SRAM reads are queued by the
// stimulus and checked by independent monitors. Follows ROM_PREFETCH_EN if defined.
module tb_rom_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic [10:0] req_addr = '0;
  logic        req_ready, rsp_valid, oram_csb;
  logic [7:0]  rsp_data;
  logic [8:0]  oram_addr;
  logic [31:0] oram_value = '0;
  logic [31:0] mem [512];

`ifdef ROM_PREFETCH_EN
  localparam bit PF_ON = 1'b1;
`else
  localparam bit PF_ON = 1'b0;
`endif

  rom_fetch_unit #(.ADDR_W(11), .WORD_AW(9)) dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .oram_csb(oram_csb), .oram_addr(oram_addr), .oram_value(oram_value)
  );

  always #5 clk = ~clk;

  // SRAM port-1 model: address sampled on the edge where csb is low, data held afterwards.
  always @(posedge clk) if (!oram_csb) oram_value <= mem[oram_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic [7:0] data; int cyc;} rsp_t;
  rsp_t rsp_q[$];
  int   addr_q[$];
  rsp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (rsp_q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
      else begin
        mon_e = rsp_q.pop_front();
        chk("rsp_data", {24'd0, rsp_data}, {24'd0, mon_e.data});
        chk("rsp_latency", cyc, mon_e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && !oram_csb) begin
      if (addr_q.size() == 0) chk("unexpected_sram_read", {23'd0, oram_addr}, 32'hFFFF_FFFF);
      else chk("oram_addr", {23'd0, oram_addr}, addr_q.pop_front());
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
    chk("req_ready_timeout", 32'd0, 32'd1);
  endtask

  // hit=1: one-cycle latency, no SRAM read; pfw>=0: prefetch read expected when enabled.
  task automatic do_req(input logic [10:0] a, input logic [7:0] exp, input bit hit, input int pfw);
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    req_valid = 1'b1;
    req_addr  = a;
    rsp_q.push_back('{exp, cyc + (hit ? 1 : 3)});
    if (!hit) addr_q.push_back(int'(a[10:2]));
    if (PF_ON && pfw >= 0) addr_q.push_back(pfw);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic do_flush();
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
  endtask

  initial begin
    bit ok;
    for (int i = 0; i < 512; i++) mem[i] = 32'hA5A5_0000 + i;
    mem[0]   = 32'h4433_2211;
    mem[5]   = 32'hDDCC_BBAA;
    mem[9]   = 32'h9988_7766;
    mem[511] = 32'h1234_5678;

    #2 rst_n = 1'b0;
    #10;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_oram_csb",  {31'd0, oram_csb},  32'd1);
    chk("rst_oram_addr", {23'd0, oram_addr}, 32'd0);
    chk("rst_rsp_data",  {24'd0, rsp_data},  32'd0);
    @(negedge clk) rst_n = 1'b1;

    do_req(11'h014, 8'hAA, 1'b0, 6);
    do_req(11'h015, 8'hBB, 1'b1, -1);
    do_req(11'h016, 8'hCC, 1'b1, -1);
    do_req(11'h017, 8'hDD, 1'b1, -1);
    do_req(11'h7FF, 8'h12, 1'b0, 0);
    do_req(11'h000, 8'h11, PF_ON, -1);
    do_req(11'h014, 8'hAA, 1'b0, 6);
    do_req(11'h015, 8'hBB, 1'b1, -1);
    do_flush();
    do_req(11'h014, 8'hAA, 1'b0, 6);

    // Miss on word 9 with flush held during the WAIT cycle.
    wait_ready(ok);
    if (ok) begin
      req_valid = 1'b1;
      req_addr  = 11'h026;
      rsp_q.push_back('{8'h88, cyc + 3});
      addr_q.push_back(9);
      if (PF_ON) addr_q.push_back(10);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
    end
    do_req(11'h024, 8'h66, 1'b0, -1);

    // Reset asserted while the miss for 0x100 is in ISSUE.
    wait_ready(ok);
    if (ok) begin
      req_valid = 1'b1;
      req_addr  = 11'h100;
      @(posedge clk);
      #1 req_valid = 1'b0;
      chk("issue_csb_low", {31'd0, oram_csb}, 32'd0);
      rst_n = 1'b0;
      #1;
      chk("midrst_oram_csb",  {31'd0, oram_csb},  32'd1);
      chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      #1 chk("postrst_req_ready", {31'd0, req_ready}, 32'd1);
    end
    do_req(11'h014, 8'hAA, 1'b0, 6);

    repeat (12) @(negedge clk);
    chk("pending_responses", rsp_q.size(), 32'd0);
    chk("pending_sram_reads", addr_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
